// File: rtl/egress_rr_reader_pkg.sv
// Shared constants and types for the egress round-robin reader.
// The top level takes its parameter defaults from here.
package egress_rr_reader_pkg;

    localparam int PORT_NUB_TOTAL = 4;
    localparam int DATA_WIDTH     = 32;
    localparam int DEPTH          = 16;
    localparam int EGR_RD_LATENCY = 1;
    localparam int EGR_OUT_DEPTH  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_GUARD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/egress_port_arb.sv
// Per-output-port VOQ reader: round-robin source pick, credit tracking,
// read-latency pipe and first-word-fall-through output FIFO.
module egress_port_arb
    import egress_rr_reader_pkg::*;
#(
    parameter int N          = 4,
    parameter int DW         = 32,
    parameter int RD_LATENCY = 1,
    parameter int OUT_DEPTH  = 4,
    parameter int PORT_ID    = 0
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           empty,
    input  logic [DW-1:0]          voq_data,
    output logic [$clog2(N)-1:0]   rd_sel,
    output logic                   rd_en,
    output logic                   out_vld,
    output logic [$clog2(N)-1:0]   out_src,
    output logic [DW-1:0]          out_data,
    input  logic                   out_rdy,
    output logic                   ovf_err
);

    localparam int WS    = $clog2(N);
    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
    localparam int AW    = $clog2(OUT_DEPTH);

    arb_state_t        state, state_nxt;
    logic [WS-1:0]     sel_q, ptr, pick;
    logic              found, issue, credit;
    logic [N-1:0]      elig;
    logic [CNT_W-1:0]  used;

    logic [RD_LATENCY-1:0] pipe_vld;
    logic [WS-1:0]         pipe_src [RD_LATENCY];

    logic [WS+DW-1:0]  mem [OUT_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push, pop, full, wr_ok;

    assign rd_en  = (state == ARB_ISSUE);
    assign rd_sel = sel_q;

    // used = reads in flight (including the one being decided) + words held in the FIFO
    assign credit = (used < CNT_W'(OUT_DEPTH));

    // The source being read right now still shows non-empty until next cycle
    always_comb begin
        elig          = ~empty;
        elig[PORT_ID] = 1'b0;
        if (rd_en) begin
            elig[sel_q] = 1'b0;
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = ptr;
        for (int i = 0; i < N; i++) begin
            if (!found && elig[ptr + WS'(i)]) begin
                found = 1'b1;
                pick  = ptr + WS'(i);
            end
        end
    end

    // A different eligible source lets ISSUE chain straight into another ISSUE
    always_comb begin
        state_nxt = ARB_IDLE;
        issue     = found && credit;
        case (state)
            ARB_IDLE:  state_nxt = issue ? ARB_ISSUE : ARB_IDLE;
            ARB_ISSUE: state_nxt = issue ? ARB_ISSUE : ARB_GUARD;
            ARB_GUARD: state_nxt = issue ? ARB_ISSUE : ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            sel_q <= '0;
            ptr   <= '0;
            used  <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                sel_q <= pick;
                ptr   <= pick + WS'(1);
            end
            used <= used + CNT_W'(issue) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_src[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_en;
            pipe_src[0] <= sel_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_src[i] <= pipe_src[i-1];
            end
        end
    end

    assign push    = pipe_vld[RD_LATENCY-1];
    assign full    = (count == CNT_W'(OUT_DEPTH));
    assign out_vld = (count != '0);
    assign pop     = out_vld && out_rdy;
    assign wr_ok   = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= {pipe_src[RD_LATENCY-1], voq_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CNT_W'(wr_ok) - CNT_W'(pop);
            if (push && full && !pop) begin
                ovf_err <= 1'b1;
            end
        end
    end

    assign out_src  = out_vld ? mem[rd_ptr][WS+DW-1:DW] : '0;
    assign out_data = out_vld ? mem[rd_ptr][DW-1:0]     : '0;

endmodule

// File: rtl/egress_rr_reader.sv
// Egress reader top: one egress_port_arb per output port, buses sliced per port.
// Overflow flags of all ports are merged into a single sticky error.
module egress_rr_reader #(
    parameter int PORT_NUB_TOTAL = egress_rr_reader_pkg::PORT_NUB_TOTAL,
    parameter int DATA_WIDTH     = egress_rr_reader_pkg::DATA_WIDTH,
    parameter int RD_LATENCY     = egress_rr_reader_pkg::EGR_RD_LATENCY,
    parameter int OUT_DEPTH      = egress_rr_reader_pkg::EGR_OUT_DEPTH
)(
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [PORT_NUB_TOTAL*PORT_NUB_TOTAL-1:0]           empty_in,
    input  logic [PORT_NUB_TOTAL*DATA_WIDTH-1:0]               voq_data_in,
    output logic [PORT_NUB_TOTAL*$clog2(PORT_NUB_TOTAL)-1:0]   rd_sel_out,
    output logic [PORT_NUB_TOTAL-1:0]                          rd_en_out,
    output logic [PORT_NUB_TOTAL-1:0]                          out_vld,
    output logic [PORT_NUB_TOTAL*$clog2(PORT_NUB_TOTAL)-1:0]   out_src,
    output logic [PORT_NUB_TOTAL*DATA_WIDTH-1:0]               out_data,
    input  logic [PORT_NUB_TOTAL-1:0]                          out_rdy,
    output logic                                               ovf_err
);

    localparam int N  = PORT_NUB_TOTAL;
    localparam int DW = DATA_WIDTH;
    localparam int WS = $clog2(N);

    logic [N-1:0] port_ovf;

    for (genvar p = 0; p < N; p++) begin : g_port
        egress_port_arb #(
            .N          (N),
            .DW         (DW),
            .RD_LATENCY (RD_LATENCY),
            .OUT_DEPTH  (OUT_DEPTH),
            .PORT_ID    (p)
        ) u_arb (
            .clk      (clk),
            .rst_n    (rst_n),
            .empty    (empty_in[p*N +: N]),
            .voq_data (voq_data_in[p*DW +: DW]),
            .rd_sel   (rd_sel_out[p*WS +: WS]),
            .rd_en    (rd_en_out[p]),
            .out_vld  (out_vld[p]),
            .out_src  (out_src[p*WS +: WS]),
            .out_data (out_data[p*DW +: DW]),
            .out_rdy  (out_rdy[p]),
            .ovf_err  (port_ovf[p])
        );
    end

    assign ovf_err = |port_ovf;

endmodule

// File: tb/tb_egress_rr_reader.sv
// Self-checking bench for egress_rr_reader: VOQ queue model feeds the DUT,
// every read pushes its expected word to a per-port scoreboard queue.
module tb_egress_rr_reader;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int WS = 2;

    typedef struct packed {
        logic [WS-1:0] src;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct packed {
        int            cyc;
        logic [WS-1:0] sel;
    } rd_rec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N*N-1:0]    empty_in;
    logic [N*DW-1:0]   voq_data_in;
    logic [N*WS-1:0]   rd_sel_out;
    logic [N-1:0]      rd_en_out;
    logic [N-1:0]      out_vld;
    logic [N*WS-1:0]   out_src;
    logic [N*DW-1:0]   out_data;
    logic [N-1:0]      out_rdy;
    logic              ovf_err;

    logic [DW-1:0]     voq_q  [N*N][$];
    exp_t              exp_q  [N][$];
    rd_rec_t           rd_log [N][$];
    logic [DW-1:0]     pend_data [N];
    logic [N-1:0]      pend_vld;
    logic [N*N-1:0]    force_nonempty;
    logic [N-1:0]      rdy_force;
    bit                rdy_random;
    int                cycle_cnt;
    int                checks;
    int                passed;
    int                seq;

    egress_rr_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .empty_in    (empty_in),
        .voq_data_in (voq_data_in),
        .rd_sel_out  (rd_sel_out),
        .rd_en_out   (rd_en_out),
        .out_vld     (out_vld),
        .out_src     (out_src),
        .out_data    (out_data),
        .out_rdy     (out_rdy),
        .ovf_err     (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushWord(input int p, input int s);
        voq_q[p*N+s].push_back({8'(p), 8'(s), 16'(seq)});
        seq++;
    endtask

    task automatic clearLogs();
        for (int p = 0; p < N; p++) begin
            rd_log[p].delete();
        end
    endtask

    // Called at the falling edge: consume reads from the VOQ model, retire accepted words
    task automatic sampleOutputs();
        for (int p = 0; p < N; p++) begin
            pend_vld[p] = 1'b0;
            if (rd_en_out[p]) begin
                int            s;
                rd_rec_t       r;
                logic [DW-1:0] w;
                exp_t          e;
                s     = int'(rd_sel_out[p*WS +: WS]);
                r.cyc = cycle_cnt;
                r.sel = WS'(s);
                rd_log[p].push_back(r);
                checkOutput($sformatf("rd_nonempty_p%0d_s%0d", p, s),
                            64'(voq_q[p*N+s].size() != 0), 64'd1);
                if (voq_q[p*N+s].size() != 0) begin
                    w            = voq_q[p*N+s].pop_front();
                    pend_data[p] = w;
                    pend_vld[p]  = 1'b1;
                    e.src        = WS'(s);
                    e.data       = w;
                    exp_q[p].push_back(e);
                end
            end
            if (out_vld[p] && out_rdy[p]) begin
                exp_t e;
                checkOutput($sformatf("out_expected_p%0d", p), 64'(exp_q[p].size() != 0), 64'd1);
                if (exp_q[p].size() != 0) begin
                    e = exp_q[p].pop_front();
                    checkOutput($sformatf("out_src_p%0d", p), 64'(out_src[p*WS +: WS]), 64'(e.src));
                    checkOutput($sformatf("out_data_p%0d", p), 64'(out_data[p*DW +: DW]), 64'(e.data));
                end
            end
        end
    endtask

    // One clock cycle: drive VOQ flags/data and out_rdy just after the edge, sample mid-cycle
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        cycle_cnt++;
        for (int p = 0; p < N; p++) begin
            voq_data_in[p*DW +: DW] = pend_vld[p] ? pend_data[p] : DW'($urandom());
        end
        for (int i = 0; i < N*N; i++) begin
            empty_in[i] = (voq_q[i].size() == 0) && !force_nonempty[i];
        end
        out_rdy = rdy_random ? N'($urandom()) : rdy_force;
        @(negedge clk);
        sampleOutputs();
    endtask

    initial begin
        int  t0;
        int  total;
        bit  found;
        logic [WS-1:0] exp_sel [4];

        checks         = 0;
        passed         = 0;
        seq            = 0;
        cycle_cnt      = 0;
        rst_n          = 1'b0;
        empty_in       = '1;
        voq_data_in    = '0;
        out_rdy        = '0;
        force_nonempty = '0;
        rdy_force      = '0;
        rdy_random     = 1'b0;
        pend_vld       = '0;

        // Reset values
        #2;
        checkOutput("rst_rd_en",    64'(rd_en_out),  64'd0);
        checkOutput("rst_rd_sel",   64'(rd_sel_out), 64'd0);
        checkOutput("rst_out_vld",  64'(out_vld),    64'd0);
        checkOutput("rst_out_src",  64'(out_src),    64'd0);
        checkOutput("rst_out_data", 64'(out_data),   64'd0);
        checkOutput("rst_ovf",      64'(ovf_err),    64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // All VOQs empty: no reads for 20 cycles
        clearLogs();
        repeat (20) applyStimulus();
        total = 0;
        for (int p = 0; p < N; p++) total += rd_log[p].size();
        checkOutput("idle_rd_count", 64'(total),   64'd0);
        checkOutput("idle_out_vld",  64'(out_vld), 64'd0);

        // Port 0, single source 2: one read every other cycle
        rdy_force = '1;
        clearLogs();
        for (int k = 0; k < 3; k++) pushWord(0, 2);
        t0 = cycle_cnt + 1;
        repeat (15) applyStimulus();
        checkOutput("t2_rd_count", 64'(rd_log[0].size()), 64'd3);
        if (rd_log[0].size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("t2_sel_%0d", k), 64'(rd_log[0][k].sel), 64'd2);
                checkOutput($sformatf("t2_cyc_%0d", k), 64'(rd_log[0][k].cyc), 64'(t0 + 1 + 2*k));
            end
        end
        checkOutput("t2_drained", 64'(exp_q[0].size()), 64'd0);

        // Port 1, sources 0,2,3 with self flag forced non-empty: back-to-back 0,2,3,0
        clearLogs();
        force_nonempty[1*N+1] = 1'b1;
        pushWord(1, 0);
        pushWord(1, 0);
        pushWord(1, 2);
        pushWord(1, 3);
        exp_sel[0] = 2'd0;
        exp_sel[1] = 2'd2;
        exp_sel[2] = 2'd3;
        exp_sel[3] = 2'd0;
        t0 = cycle_cnt + 1;
        repeat (15) applyStimulus();
        checkOutput("t3_rd_count", 64'(rd_log[1].size()), 64'd4);
        if (rd_log[1].size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput($sformatf("t3_sel_%0d", k), 64'(rd_log[1][k].sel), 64'(exp_sel[k]));
                checkOutput($sformatf("t3_cyc_%0d", k), 64'(rd_log[1][k].cyc), 64'(t0 + 1 + k));
            end
        end
        force_nonempty = '0;
        checkOutput("t3_drained", 64'(exp_q[1].size()), 64'd0);

        // Port 2 stalled: credit limits reads to the FIFO depth, head word held
        clearLogs();
        rdy_force = 4'b1011;
        for (int k = 0; k < 10; k++) pushWord(2, 0);
        repeat (20) applyStimulus();
        checkOutput("t4_rd_stall",  64'(rd_log[2].size()), 64'd4);
        checkOutput("t4_vld_held",  64'(out_vld[2]),       64'd1);
        if (exp_q[2].size() != 0) begin
            checkOutput("t4_data_held", 64'(out_data[2*DW +: DW]), 64'(exp_q[2][0].data));
            checkOutput("t4_src_held",  64'(out_src[2*WS +: WS]),  64'(exp_q[2][0].src));
        end
        checkOutput("t4_ovf_stall", 64'(ovf_err), 64'd0);
        rdy_force = '1;
        repeat (40) applyStimulus();
        checkOutput("t4_rd_total",  64'(rd_log[2].size()),       64'd10);
        checkOutput("t4_drained",   64'(exp_q[2].size()),        64'd0);
        checkOutput("t4_voq_empty", 64'(voq_q[2*N+0].size()),    64'd0);
        checkOutput("t4_ovf",       64'(ovf_err),                64'd0);

        // Port 3: reset while a returned word is in the pipe
        clearLogs();
        pushWord(3, 1);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            applyStimulus();
            if (rd_log[3].size() != 0) found = 1'b1;
        end
        checkOutput("t5_rd_seen", 64'(found), 64'd1);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        pend_vld = '0;
        for (int p = 0; p < N; p++) exp_q[p].delete();
        #1;
        checkOutput("t5_rst_vld",   64'(out_vld),   64'd0);
        checkOutput("t5_rst_rd_en", 64'(rd_en_out), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clearLogs();
        pushWord(3, 1);
        pushWord(3, 2);
        repeat (15) applyStimulus();
        checkOutput("t5_rd_count", 64'(rd_log[3].size()), 64'd2);
        if (rd_log[3].size() == 2) begin
            checkOutput("t5_ptr_restart", 64'(rd_log[3][0].sel), 64'd1);
            checkOutput("t5_second_sel",  64'(rd_log[3][1].sel), 64'd2);
        end
        checkOutput("t5_drained", 64'(exp_q[3].size()), 64'd0);

        // Random traffic and back-pressure on all ports
        clearLogs();
        rdy_random = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                int p;
                int s;
                p = int'($urandom_range(0, N-1));
                s = int'($urandom_range(0, N-1));
                if (s != p && voq_q[p*N+s].size() < 8) pushWord(p, s);
            end
            applyStimulus();
        end
        rdy_random = 1'b0;
        rdy_force  = '1;
        repeat (200) applyStimulus();
        for (int p = 0; p < N; p++) begin
            checkOutput($sformatf("t6_drained_p%0d", p), 64'(exp_q[p].size()), 64'd0);
        end
        total = 0;
        for (int i = 0; i < N*N; i++) total += voq_q[i].size();
        checkOutput("t6_voq_left", 64'(total),   64'd0);
        checkOutput("t6_ovf",      64'(ovf_err), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
